// File: rtl/regfile_mp_pkg.sv
// Shared widths and types for the multi-ported register file.
// Imported by the interface, the operand lookup and the top level.
package regfile_mp_pkg;
    localparam int XLEN          = 32;
    localparam int REG_NUM       = 32;
    localparam int REG_ID_BIT    = 5;
    localparam int ROB_WIDTH_BIT = 4;
    localparam int DISP_W        = 2;
    localparam int CMT_W         = 2;

    typedef logic [XLEN-1:0]          word_t;
    typedef logic [REG_ID_BIT-1:0]    reg_id_t;
    typedef logic [ROB_WIDTH_BIT-1:0] rob_tag_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Dispatch, operand-read and commit bundle of the register file.
// master: dispatch/ROB side drives requests; slave: register file answers.
interface regfile_mp_if;
    import regfile_mp_pkg::*;

    logic                    rdy_in;
    logic                    flush_in;
    logic [DISP_W-1:0]       disp_valid_in;
    reg_id_t  [DISP_W-1:0]   disp_rd_in;
    rob_tag_t [DISP_W-1:0]   disp_tag_in;
    reg_id_t  [DISP_W-1:0]   disp_rs1_in;
    reg_id_t  [DISP_W-1:0]   disp_rs2_in;
    logic [DISP_W-1:0]       rs1_busy_out;
    logic [DISP_W-1:0]       rs2_busy_out;
    word_t    [DISP_W-1:0]   rs1_value_out;
    word_t    [DISP_W-1:0]   rs2_value_out;
    rob_tag_t [DISP_W-1:0]   rs1_tag_out;
    rob_tag_t [DISP_W-1:0]   rs2_tag_out;
    logic [CMT_W-1:0]        cmt_valid_in;
    reg_id_t  [CMT_W-1:0]    cmt_rd_in;
    rob_tag_t [CMT_W-1:0]    cmt_tag_in;
    word_t    [CMT_W-1:0]    cmt_value_in;

    modport master (
        output rdy_in, flush_in,
        output disp_valid_in, disp_rd_in, disp_tag_in,
        output disp_rs1_in, disp_rs2_in,
        output cmt_valid_in, cmt_rd_in, cmt_tag_in, cmt_value_in,
        input  rs1_busy_out, rs2_busy_out,
        input  rs1_value_out, rs2_value_out,
        input  rs1_tag_out, rs2_tag_out
    );

    modport slave (
        input  rdy_in, flush_in,
        input  disp_valid_in, disp_rd_in, disp_tag_in,
        input  disp_rs1_in, disp_rs2_in,
        input  cmt_valid_in, cmt_rd_in, cmt_tag_in, cmt_value_in,
        output rs1_busy_out, rs2_busy_out,
        output rs1_value_out, rs2_value_out,
        output rs1_tag_out, rs2_tag_out
    );
endinterface

// File: rtl/regfile_operand_lookup.sv
// Resolves one source operand: x0, earlier-slot rename, commit bypass, state.
// Ports: r + stored busy/tag/value of r, dispatch and commit vectors in; busy/value/tag out.
module regfile_operand_lookup
    import regfile_mp_pkg::*;
#(
    parameter int SLOT = 0
) (
    input  reg_id_t                r,
    input  logic                   st_busy,
    input  rob_tag_t               st_tag,
    input  word_t                  st_value,
    input  logic [DISP_W-1:0]      disp_valid,
    input  reg_id_t  [DISP_W-1:0]  disp_rd,
    input  rob_tag_t [DISP_W-1:0]  disp_tag,
    input  logic [CMT_W-1:0]       cmt_valid,
    input  reg_id_t  [CMT_W-1:0]   cmt_rd,
    input  rob_tag_t [CMT_W-1:0]   cmt_tag,
    input  word_t    [CMT_W-1:0]   cmt_value,
    output logic                   busy,
    output word_t                  value,
    output rob_tag_t               tag
);
    logic     hit_disp;
    rob_tag_t disp_hit_tag;
    logic     hit_cmt;
    word_t    cmt_hit_value;

    always_comb begin
        hit_disp      = 1'b0;
        disp_hit_tag  = '0;
        hit_cmt       = 1'b0;
        cmt_hit_value = '0;
        // Later iterations overwrite: youngest earlier slot / highest port wins.
        for (int j = 0; j < DISP_W; j++) begin
            if (j < SLOT && disp_valid[j] && disp_rd[j] == r) begin
                hit_disp     = 1'b1;
                disp_hit_tag = disp_tag[j];
            end
        end
        for (int c = 0; c < CMT_W; c++) begin
            if (cmt_valid[c] && cmt_rd[c] == r && cmt_tag[c] == st_tag) begin
                hit_cmt       = 1'b1;
                cmt_hit_value = cmt_value[c];
            end
        end
    end

    always_comb begin
        busy  = 1'b0;
        value = '0;
        tag   = '0;
        if (r == '0) begin
            busy = 1'b0;
        end else if (hit_disp) begin
            busy = 1'b1;
            tag  = disp_hit_tag;
        end else if (st_busy && hit_cmt) begin
            value = cmt_hit_value;
        end else if (st_busy) begin
            busy = 1'b1;
            tag  = st_tag;
        end else begin
            value = st_value;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported architectural register file with busy/ROB-tag rename table.
// Ports: clk_in, rst_in (async active-low), bus (regfile_mp_if.slave).
module regfile_mp
    import regfile_mp_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    regfile_mp_if.slave  bus
);
    word_t    [REG_NUM-1:0] regs, regs_nxt;
    logic     [REG_NUM-1:0] busy, busy_nxt, clr;
    rob_tag_t [REG_NUM-1:0] tag, tag_nxt;

    logic     [DISP_W-1:0]  rs1_busy, rs2_busy;
    word_t    [DISP_W-1:0]  rs1_value, rs2_value;
    rob_tag_t [DISP_W-1:0]  rs1_tag, rs2_tag;

    // Commit, then rename (overrides a same-cycle clear), then flush.
    always_comb begin
        regs_nxt = regs;
        busy_nxt = busy;
        tag_nxt  = tag;
        clr      = '0;
        for (int c = 0; c < CMT_W; c++) begin
            if (bus.cmt_valid_in[c] && bus.cmt_rd_in[c] != '0) begin
                regs_nxt[bus.cmt_rd_in[c]] = bus.cmt_value_in[c];
                clr[bus.cmt_rd_in[c]] =
                    (tag[bus.cmt_rd_in[c]] == bus.cmt_tag_in[c]);
            end
        end
        busy_nxt = busy & ~clr;
        for (int k = 0; k < DISP_W; k++) begin
            if (bus.disp_valid_in[k] && bus.disp_rd_in[k] != '0) begin
                busy_nxt[bus.disp_rd_in[k]] = 1'b1;
                tag_nxt[bus.disp_rd_in[k]]  = bus.disp_tag_in[k];
            end
        end
        if (bus.flush_in) begin
            busy_nxt = '0;
            tag_nxt  = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs <= '0;
            busy <= '0;
            tag  <= '0;
        end else if (bus.rdy_in) begin
            regs <= regs_nxt;
            busy <= busy_nxt;
            tag  <= tag_nxt;
        end
    end

    for (genvar k = 0; k < DISP_W; k++) begin : g_slot
        regfile_operand_lookup #(.SLOT(k)) u_rs1 (
            .r          (bus.disp_rs1_in[k]),
            .st_busy    (busy[bus.disp_rs1_in[k]]),
            .st_tag     (tag[bus.disp_rs1_in[k]]),
            .st_value   (regs[bus.disp_rs1_in[k]]),
            .disp_valid (bus.disp_valid_in),
            .disp_rd    (bus.disp_rd_in),
            .disp_tag   (bus.disp_tag_in),
            .cmt_valid  (bus.cmt_valid_in),
            .cmt_rd     (bus.cmt_rd_in),
            .cmt_tag    (bus.cmt_tag_in),
            .cmt_value  (bus.cmt_value_in),
            .busy       (rs1_busy[k]),
            .value      (rs1_value[k]),
            .tag        (rs1_tag[k])
        );
        regfile_operand_lookup #(.SLOT(k)) u_rs2 (
            .r          (bus.disp_rs2_in[k]),
            .st_busy    (busy[bus.disp_rs2_in[k]]),
            .st_tag     (tag[bus.disp_rs2_in[k]]),
            .st_value   (regs[bus.disp_rs2_in[k]]),
            .disp_valid (bus.disp_valid_in),
            .disp_rd    (bus.disp_rd_in),
            .disp_tag   (bus.disp_tag_in),
            .cmt_valid  (bus.cmt_valid_in),
            .cmt_rd     (bus.cmt_rd_in),
            .cmt_tag    (bus.cmt_tag_in),
            .cmt_value  (bus.cmt_value_in),
            .busy       (rs2_busy[k]),
            .value      (rs2_value[k]),
            .tag        (rs2_tag[k])
        );
    end

    assign bus.rs1_busy_out  = rs1_busy;
    assign bus.rs2_busy_out  = rs2_busy;
    assign bus.rs1_value_out = rs1_value;
    assign bus.rs2_value_out = rs2_value;
    assign bus.rs1_tag_out   = rs1_tag;
    assign bus.rs2_tag_out   = rs2_tag;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed vectors push expected operands,
// a negedge monitor pops and compares against the live read outputs.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    typedef struct {
        string    name;
        int       slot;
        bit       second;
        bit       busy;
        word_t    value;
        rob_tag_t tag;
    } exp_t;

    logic clk_in;
    logic rst_in;
    regfile_mp_if bus ();

    regfile_mp dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        while (q.size() > 0) begin
            exp_t e;
            logic     b;
            word_t    v;
            rob_tag_t t;
            e = q.pop_front();
            if (e.second) begin
                b = bus.rs2_busy_out[e.slot];
                v = bus.rs2_value_out[e.slot];
                t = bus.rs2_tag_out[e.slot];
            end else begin
                b = bus.rs1_busy_out[e.slot];
                v = bus.rs1_value_out[e.slot];
                t = bus.rs1_tag_out[e.slot];
            end
            compared++;
            if (b !== e.busy || v !== e.value || t !== e.tag) begin
                mismatched++;
                $display("FAIL %s: got busy=%0d value=%h tag=%0d, want busy=%0d value=%h tag=%0d",
                         e.name, b, v, t, e.busy, e.value, e.tag);
            end
        end
    end

    task automatic clear_in();
        bus.rdy_in        = 1'b1;
        bus.flush_in      = 1'b0;
        bus.disp_valid_in = '0;
        bus.disp_rd_in    = '0;
        bus.disp_tag_in   = '0;
        bus.disp_rs1_in   = '0;
        bus.disp_rs2_in   = '0;
        bus.cmt_valid_in  = '0;
        bus.cmt_rd_in     = '0;
        bus.cmt_tag_in    = '0;
        bus.cmt_value_in  = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        clear_in();
    endtask

    task automatic ren(input int s, input reg_id_t rd, input rob_tag_t t);
        bus.disp_valid_in[s] = 1'b1;
        bus.disp_rd_in[s]    = rd;
        bus.disp_tag_in[s]   = t;
    endtask

    task automatic cmt(input int p, input reg_id_t rd, input rob_tag_t t,
                       input word_t v);
        bus.cmt_valid_in[p] = 1'b1;
        bus.cmt_rd_in[p]    = rd;
        bus.cmt_tag_in[p]   = t;
        bus.cmt_value_in[p] = v;
    endtask

    task automatic chk(input string nm, input int s, input bit second,
                       input reg_id_t r, input bit b, input word_t v,
                       input rob_tag_t t);
        exp_t e;
        if (second) bus.disp_rs2_in[s] = r;
        else        bus.disp_rs1_in[s] = r;
        e.name   = nm;
        e.slot   = s;
        e.second = second;
        e.busy   = b;
        e.value  = v;
        e.tag    = t;
        q.push_back(e);
    endtask

    initial begin
        rst_in = 1'b0;
        clear_in();

        step();
        chk("in_reset_x5_s0", 0, 0, 5'd5, 0, 32'h0, 4'd0);
        chk("in_reset_x5_s1", 1, 0, 5'd5, 0, 32'h0, 4'd0);

        step();
        rst_in = 1'b1;
        cmt(0, 5'd5, 4'd3, 32'hDEAD);
        chk("x5_pre_commit_s0", 0, 0, 5'd5, 0, 32'h0, 4'd0);
        chk("x5_pre_commit_s1", 1, 0, 5'd5, 0, 32'h0, 4'd0);
        chk("x0_read", 0, 1, 5'd0, 0, 32'h0, 4'd0);

        step();
        chk("x5_committed", 0, 0, 5'd5, 0, 32'hDEAD, 4'd0);

        step();
        ren(0, 5'd7, 4'd2);
        chk("x7_intra_group", 1, 0, 5'd7, 1, 32'h0, 4'd2);
        chk("x7_own_slot", 0, 0, 5'd7, 0, 32'h0, 4'd0);

        step();
        chk("x7_busy_state", 0, 0, 5'd7, 1, 32'h0, 4'd2);

        step();
        ren(0, 5'd9, 4'd4);
        ren(1, 5'd9, 4'd5);
        chk("x9_slot1_sees_s0", 1, 1, 5'd9, 1, 32'h0, 4'd4);

        step();
        cmt(0, 5'd9, 4'd5, 32'h7777);
        cmt(1, 5'd9, 4'd5, 32'h1234);
        chk("x9_cmt_bypass_s0", 0, 0, 5'd9, 0, 32'h1234, 4'd0);
        chk("x9_cmt_bypass_s1", 1, 0, 5'd9, 0, 32'h1234, 4'd0);

        step();
        chk("x9_after_commit", 0, 0, 5'd9, 0, 32'h1234, 4'd0);

        step();
        ren(0, 5'd4, 4'd1);
        step();
        ren(0, 5'd4, 4'd6);
        chk("x4_tag1", 0, 0, 5'd4, 1, 32'h0, 4'd1);

        step();
        cmt(0, 5'd4, 4'd1, 32'h11);
        chk("x4_stale_cmt_nobypass", 0, 0, 5'd4, 1, 32'h0, 4'd6);

        step();
        chk("x4_still_busy", 0, 0, 5'd4, 1, 32'h0, 4'd6);

        step();
        cmt(0, 5'd4, 4'd6, 32'h66);
        ren(0, 5'd4, 4'd8);
        chk("x4_cmt_bypass", 0, 0, 5'd4, 0, 32'h66, 4'd0);
        chk("x4_rename_intra", 1, 0, 5'd4, 1, 32'h0, 4'd8);

        step();
        chk("x4_rename_wins", 0, 0, 5'd4, 1, 32'h0, 4'd8);

        step();
        ren(0, 5'd3, 4'd10);
        step();
        chk("x3_busy", 0, 0, 5'd3, 1, 32'h0, 4'd10);
        chk("x4_busy_pre_flush", 0, 1, 5'd4, 1, 32'h0, 4'd8);

        step();
        bus.flush_in = 1'b1;
        ren(0, 5'd10, 4'd9);
        cmt(0, 5'd3, 4'd10, 32'h55);
        chk("x10_flush_cycle_read", 1, 0, 5'd10, 1, 32'h0, 4'd9);

        step();
        chk("x3_after_flush", 0, 0, 5'd3, 0, 32'h55, 4'd0);
        chk("x4_after_flush", 0, 1, 5'd4, 0, 32'h66, 4'd0);
        chk("x10_discarded", 1, 0, 5'd10, 0, 32'h0, 4'd0);
        chk("x9_after_flush", 1, 1, 5'd9, 0, 32'h1234, 4'd0);

        step();
        bus.rdy_in = 1'b0;
        cmt(0, 5'd5, 4'd0, 32'hBEEF);
        ren(0, 5'd6, 4'd7);
        chk("stall_intra_live", 1, 0, 5'd6, 1, 32'h0, 4'd7);
        chk("stall_x5_read", 0, 0, 5'd5, 0, 32'hDEAD, 4'd0);

        step();
        chk("stall_no_write", 0, 0, 5'd5, 0, 32'hDEAD, 4'd0);
        chk("stall_no_rename", 0, 1, 5'd6, 0, 32'h0, 4'd0);

        step();
        ren(0, 5'd12, 4'd3);
        step();
        chk("x12_busy", 0, 0, 5'd12, 1, 32'h0, 4'd3);
        chk("x5_before_reset", 1, 0, 5'd5, 0, 32'hDEAD, 4'd0);

        step();
        rst_in = 1'b0;
        chk("async_rst_x12", 0, 0, 5'd12, 0, 32'h0, 4'd0);
        chk("async_rst_x5", 1, 0, 5'd5, 0, 32'h0, 4'd0);
        chk("async_rst_x9", 0, 1, 5'd9, 0, 32'h0, 4'd0);

        step();
        rst_in = 1'b1;
        chk("post_rst_x9", 0, 0, 5'd9, 0, 32'h0, 4'd0);

        @(negedge clk_in);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
